// File: rtl/eth_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : eth_tx_arbiter
//  Description : Two-requester frame arbiter feeding a shared 10GbE MAC TX
//                AXI-Stream. Grants a whole frame at a time and alternates
//                between requesters on a tie. After each frame it inserts
//                IFG_CYCLES idle cycles.
//                Optional per-port frame counters are enabled by defining
//                the macro ETH_TX_ARB_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module eth_tx_arbiter #(
   parameter logic [15:0] IFG_CYCLES = 16'd4
) (
   input  logic        clk156,
   input  logic        eth_rst,
   // requester 0 (frame generator)
   input  logic        s0_axis_tvalid,
   output logic        s0_axis_tready,
   input  logic [63:0] s0_axis_tdata,
   input  logic [7:0]  s0_axis_tkeep,
   input  logic        s0_axis_tlast,
   input  logic        s0_axis_tuser,
   // requester 1 (forwarding path)
   input  logic        s1_axis_tvalid,
   output logic        s1_axis_tready,
   input  logic [63:0] s1_axis_tdata,
   input  logic [7:0]  s1_axis_tkeep,
   input  logic        s1_axis_tlast,
   input  logic        s1_axis_tuser,
   // shared MAC TX stream
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   output logic [63:0] m_axis_tdata,
   output logic [7:0]  m_axis_tkeep,
   output logic        m_axis_tlast,
   output logic        m_axis_tuser,
`ifdef ETH_TX_ARB_STATS_EN
   output logic [31:0] s0_frame_cnt,
   output logic [31:0] s1_frame_cnt,
`endif
   output logic [1:0]  grant
);

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_S0   = 2'd1,
      ARB_S1   = 2'd2,
      ARB_GAP  = 2'd3
   } arb_state_t;

   arb_state_t  state_q, state_d;
   logic        last_served_q, last_served_d;   // 0 = s0, 1 = s1
   logic [15:0] gap_cnt_q, gap_cnt_d;

   logic        w_own0;
   logic        w_own1;
   logic        w_beat_last;

   // Ownership is masked by reset so no beat can be handshaken on the edge
   // that takes the reset.
   assign w_own0      = (state_q == ARB_S0) & ~eth_rst;
   assign w_own1      = (state_q == ARB_S1) & ~eth_rst;
   assign w_beat_last = m_axis_tvalid & m_axis_tready & m_axis_tlast;

   // State, tie-break memory and inter-frame gap counter registers
   always_ff @(posedge clk156) begin
      if (eth_rst) begin
         state_q       <= ARB_IDLE;
         last_served_q <= 1'b1;
         gap_cnt_q     <= 16'd0;
      end else begin
         state_q       <= state_d;
         last_served_q <= last_served_d;
         gap_cnt_q     <= gap_cnt_d;
      end
   end

   // Next-state logic: arbitrate in IDLE, hold grant to end of frame, then gap
   always_comb begin
      state_d       = state_q;
      last_served_d = last_served_q;
      gap_cnt_d     = gap_cnt_q;
      case (state_q)
         ARB_IDLE: begin
            if (s0_axis_tvalid && !s1_axis_tvalid) begin
               state_d       = ARB_S0;
               last_served_d = 1'b0;
            end else if (s1_axis_tvalid && !s0_axis_tvalid) begin
               state_d       = ARB_S1;
               last_served_d = 1'b1;
            end else if (s0_axis_tvalid && s1_axis_tvalid) begin
               // tie: serve whichever port did not go last
               if (last_served_q) begin
                  state_d       = ARB_S0;
                  last_served_d = 1'b0;
               end else begin
                  state_d       = ARB_S1;
                  last_served_d = 1'b1;
               end
            end
         end
         ARB_S0, ARB_S1: begin
            if (w_beat_last) begin
               gap_cnt_d = 16'd0;
               state_d   = (IFG_CYCLES != 16'd0) ? ARB_GAP : ARB_IDLE;
            end
         end
         ARB_GAP: begin
            gap_cnt_d = gap_cnt_q + 16'd1;
            if (gap_cnt_q == (IFG_CYCLES - 16'd1)) begin
               state_d = ARB_IDLE;
            end
         end
         default: begin
            state_d = ARB_IDLE;
         end
      endcase
   end

   // Output mux: owner's stream passes straight through, otherwise all quiet
   always_comb begin
      m_axis_tvalid  = 1'b0;
      m_axis_tdata   = 64'h0;
      m_axis_tkeep   = 8'h00;
      m_axis_tlast   = 1'b0;
      m_axis_tuser   = 1'b0;
      s0_axis_tready = 1'b0;
      s1_axis_tready = 1'b0;
      if (w_own0) begin
         m_axis_tvalid  = s0_axis_tvalid;
         m_axis_tdata   = s0_axis_tdata;
         m_axis_tkeep   = s0_axis_tkeep;
         m_axis_tlast   = s0_axis_tlast;
         m_axis_tuser   = s0_axis_tuser;
         s0_axis_tready = m_axis_tready;
      end else if (w_own1) begin
         m_axis_tvalid  = s1_axis_tvalid;
         m_axis_tdata   = s1_axis_tdata;
         m_axis_tkeep   = s1_axis_tkeep;
         m_axis_tlast   = s1_axis_tlast;
         m_axis_tuser   = s1_axis_tuser;
         s1_axis_tready = m_axis_tready;
      end
   end

   assign grant = {w_own1, w_own0};

`ifdef ETH_TX_ARB_STATS_EN
   logic [31:0] s0_cnt_q;
   logic [31:0] s1_cnt_q;

   // Per-port count of completed frames, free-running with natural wrap
   always_ff @(posedge clk156) begin
      if (eth_rst) begin
         s0_cnt_q <= 32'd0;
         s1_cnt_q <= 32'd0;
      end else begin
         if (w_own0 && w_beat_last) begin
            s0_cnt_q <= s0_cnt_q + 32'd1;
         end
         if (w_own1 && w_beat_last) begin
            s1_cnt_q <= s1_cnt_q + 32'd1;
         end
      end
   end

   assign s0_frame_cnt = s0_cnt_q;
   assign s1_frame_cnt = s1_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_eth_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_eth_tx_arbiter
//  Description : Randomized self-checking bench for eth_tx_arbiter. Sources are
//                modelled as queues of frames; expected grants, gaps and data
//                come from a frame-level ownership model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_eth_tx_arbiter;

   localparam int IFG = 4;

   typedef struct packed {
      logic [63:0] d;
      logic [7:0]  k;
      logic        l;
      logic        u;
   } beat_t;

   logic        clk156 = 1'b0;
   logic        eth_rst;
   logic        sv [2];
   logic [63:0] sd [2];
   logic [7:0]  sk [2];
   logic        sl [2];
   logic        su [2];
   logic        sr0, sr1;
   logic        m_tvalid, m_tready, m_tlast, m_tuser;
   logic [63:0] m_tdata;
   logic [7:0]  m_tkeep;
   logic [1:0]  grant;
`ifdef ETH_TX_ARB_STATS_EN
   logic [31:0] s0_frame_cnt, s1_frame_cnt;
   logic [31:0] ecnt [2];
`endif

   always #5 clk156 = ~clk156;

   eth_tx_arbiter #(.IFG_CYCLES(16'(IFG))) dut (
      .clk156         (clk156),
      .eth_rst        (eth_rst),
      .s0_axis_tvalid (sv[0]),
      .s0_axis_tready (sr0),
      .s0_axis_tdata  (sd[0]),
      .s0_axis_tkeep  (sk[0]),
      .s0_axis_tlast  (sl[0]),
      .s0_axis_tuser  (su[0]),
      .s1_axis_tvalid (sv[1]),
      .s1_axis_tready (sr1),
      .s1_axis_tdata  (sd[1]),
      .s1_axis_tkeep  (sk[1]),
      .s1_axis_tlast  (sl[1]),
      .s1_axis_tuser  (su[1]),
      .m_axis_tvalid  (m_tvalid),
      .m_axis_tready  (m_tready),
      .m_axis_tdata   (m_tdata),
      .m_axis_tkeep   (m_tkeep),
      .m_axis_tlast   (m_tlast),
      .m_axis_tuser   (m_tuser),
`ifdef ETH_TX_ARB_STATS_EN
      .s0_frame_cnt   (s0_frame_cnt),
      .s1_frame_cnt   (s1_frame_cnt),
`endif
      .grant          (grant)
   );

   int    n_total = 0;
   int    n_bad   = 0;
   int    cyc     = 0;
   beat_t q0[$];
   beat_t q1[$];
   int    pv, pr;          // percent probability of source valid / sink ready
   bit    auto_fill;
   // frame-level reference model
   int    owner;           // -1 none, else port currently owning the stream
   int    last_port;       // port granted most recently
   int    elig;            // first cycle on which a new grant may be decided
   int    t_g0, t_g1;      // first cycle grant 01 / 10 seen in a directed test

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int qsize(input int p);
      return (p == 0) ? q0.size() : q1.size();
   endfunction

   function automatic beat_t qhead(input int p);
      return (p == 0) ? q0[0] : q1[0];
   endfunction

   task automatic qpop(input int p, output beat_t b);
      if (p == 0) b = q0.pop_front();
      else        b = q1.pop_front();
   endtask

   task automatic mk_frame(input int p, input int len);
      beat_t b;
      for (int i = 0; i < len; i++) begin
         b.d = {$urandom(), $urandom()};
         b.l = (i == len - 1);
         b.k = b.l ? 8'($urandom_range(1, 255)) : 8'hFF;
         b.u = b.l ? 1'($urandom()) : 1'b0;
         if (p == 0) q0.push_back(b);
         else        q1.push_back(b);
      end
   endtask

   // Present either the head beat or junk with valid low
   task automatic drive();
      beat_t b;
      for (int p = 0; p < 2; p++) begin
         if (auto_fill && qsize(p) < 3) mk_frame(p, $urandom_range(1, 6));
         if (qsize(p) > 0 && $urandom_range(99) < pv) begin
            b     = qhead(p);
            sv[p] = 1'b1;
         end else begin
            b.d   = {$urandom(), $urandom()};
            b.k   = 8'($urandom());
            b.l   = 1'($urandom());
            b.u   = 1'($urandom());
            sv[p] = 1'b0;
         end
         sd[p] = b.d;
         sk[p] = b.k;
         sl[p] = b.l;
         su[p] = b.u;
      end
      m_tready = ($urandom_range(99) < pr);
   endtask

   // Compare outputs with the model for this cycle, then advance the model
   task automatic check_cycle();
      beat_t      b;
      logic [1:0] eg;
      int         w;
      if (eth_rst) begin
         chk("rst_tvalid", 64'(m_tvalid), 64'd0);
         chk("rst_tready", 64'({sr1, sr0}), 64'd0);
         if (owner >= 0) begin
            // abandon the remainder of the frame in flight
            while (qsize(owner) > 0) begin
               qpop(owner, b);
               if (b.l) break;
            end
         end
         owner     = -1;
         last_port = 1;
         elig      = cyc + 1;
`ifdef ETH_TX_ARB_STATS_EN
         ecnt[0] = 32'd0;
         ecnt[1] = 32'd0;
`endif
         return;
      end
      eg = (owner < 0) ? 2'b00 : ((owner == 0) ? 2'b01 : 2'b10);
      chk("grant", 64'(grant), 64'(eg));
      if (grant == 2'b01 && t_g0 < 0) t_g0 = cyc;
      if (grant == 2'b10 && t_g1 < 0) t_g1 = cyc;
`ifdef ETH_TX_ARB_STATS_EN
      chk("s0_frame_cnt", 64'(s0_frame_cnt), 64'(ecnt[0]));
      chk("s1_frame_cnt", 64'(s1_frame_cnt), 64'(ecnt[1]));
`endif
      if (owner >= 0) begin
         chk("tvalid", 64'(m_tvalid), 64'(sv[owner]));
         chk("tdata",  m_tdata, sd[owner]);
         chk("tkeep",  64'(m_tkeep), 64'(sk[owner]));
         chk("tlast",  64'(m_tlast), 64'(sl[owner]));
         chk("tuser",  64'(m_tuser), 64'(su[owner]));
         chk("s_tready", 64'({sr1, sr0}),
             64'((owner == 0) ? {1'b0, m_tready} : {m_tready, 1'b0}));
         if (sv[owner] && m_tready) begin
            qpop(owner, b);
            if (b.l) begin
`ifdef ETH_TX_ARB_STATS_EN
               ecnt[owner] = ecnt[owner] + 32'd1;
`endif
               owner = -1;
               elig  = cyc + IFG + 1;
            end
         end
      end else begin
         chk("idle_tdata", m_tdata, 64'd0);
         chk("idle_ctl", 64'({m_tvalid, m_tlast, m_tuser, m_tkeep, sr1, sr0}), 64'd0);
         if (cyc >= elig) begin
            if (sv[0] && sv[1]) w = (last_port == 0) ? 1 : 0;
            else if (sv[0])     w = 0;
            else if (sv[1])     w = 1;
            else                w = -1;
            if (w >= 0) begin
               owner     = w;
               last_port = w;
            end
         end
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         drive();
         @(negedge clk156);
         check_cycle();
         @(posedge clk156);
         #1;
         cyc++;
      end
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int pvs [6] = '{100, 80, 60, 100, 70, 50};
      int prs [6] = '{100, 100, 70, 50, 60, 40};
      int n;
      owner = -1; last_port = 1; elig = 0; t_g0 = -1; t_g1 = -1;
      pv = 100; pr = 100; auto_fill = 0;
      eth_rst = 1'b1;
      for (int p = 0; p < 2; p++) begin
         sv[p] = 1'b0; sd[p] = '0; sk[p] = '0; sl[p] = 1'b0; su[p] = 1'b0;
      end
      m_tready = 1'b1;
`ifdef ETH_TX_ARB_STATS_EN
      ecnt[0] = 32'd0;
      ecnt[1] = 32'd0;
`endif
      @(posedge clk156);
      #1;
      step(3);
      eth_rst = 1'b0;
      step(2);                         // reset state with nothing requesting

      // tie after reset: s0 first, gap, idle, then s1
      mk_frame(0, 3);
      mk_frame(1, 3);
      t_g0 = -1; t_g1 = -1;
      step(20);
      chk("tie_s0_first", 64'(t_g0 >= 0 && t_g1 > t_g0), 64'd1);
      chk("s0_to_s1_spacing", 64'(t_g1 - t_g0), 64'(3 + IFG + 1));

      // continuous contention: model enforces alternation
      auto_fill = 1;
      step(80);

      // randomized valid stalls and sink backpressure
      for (int m = 0; m < 6; m++) begin
         pv = pvs[m];
         pr = prs[m];
         step(300);
      end

      // reset during beat 2 of a 6-beat s1 frame
      auto_fill = 0;
      pv = 100; pr = 100;
      eth_rst = 1'b1;
      step(1);
      eth_rst = 1'b0;
      q0.delete();
      q1.delete();
      mk_frame(1, 6);
      n = 0;
      while (!(owner == 1 && q1.size() == 5) && n < 20) begin
         step(1);
         n++;
      end
      chk("reach_s1_beat2", 64'(n < 20), 64'd1);
      eth_rst = 1'b1;
      step(1);
      eth_rst = 1'b0;
      chk("abandoned_frame", 64'(q1.size()), 64'd0);
      mk_frame(0, 2);
      mk_frame(1, 2);
      t_g0 = -1; t_g1 = -1;
      step(16);
      chk("post_rst_s0_first", 64'(t_g0 >= 0 && t_g1 > t_g0), 64'd1);

`ifdef ETH_TX_ARB_STATS_EN
      // wrap of s0 frame counter from a preloaded value
      dut.s0_cnt_q = 32'hFFFF_FFFE;
      ecnt[0] = 32'hFFFF_FFFE;
      mk_frame(0, 2);
      mk_frame(0, 1);
      step(20);
      chk("s0_cnt_wrap", 64'(s0_frame_cnt), 64'd0);
      chk("s1_cnt_hold", 64'(s1_frame_cnt), 64'd1);
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
